// File: rtl/change_dispenser.sv
// change_dispenser
//   Coin-return end of the vending machine change path. Accepts a change
//   amount and pays it out one coin at a time, largest denomination first,
//   using only denominations that are in stock. Each coin is offered to the
//   coin ejector over a valid/ack handshake. Inserted coins are counted back
//   into stock through refill strobes.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   i_start      one-cycle request to dispense i_amount (honoured in IDLE)
//   i_amount     change to return, sampled with i_start
//   i_coin_ack   ejector accepted the offered coin
//   i_refill     bit k pulses once per inserted coin of denomination k
//   o_busy       high whenever a request is in progress
//   o_coin       one-hot denomination offered (0 when no offer)
//   o_coin_valid a coin offer is pending
//   o_done       one-cycle pulse when a request completes
//   o_remainder  amount that could not be paid out
//   o_stock      stock counters {stock2, stock1, stock0}
module change_dispenser #(
  parameter int TOTAL_BITS = 31,
  parameter int STOCK_BITS = 8,
  parameter int COIN0_VAL  = 100,
  parameter int COIN1_VAL  = 500,
  parameter int COIN2_VAL  = 1000,
  parameter int INIT_STOCK = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [TOTAL_BITS-1:0]   i_amount,
  input  logic                    i_coin_ack,
  input  logic [2:0]              i_refill,
  output logic                    o_busy,
  output logic [2:0]              o_coin,
  output logic                    o_coin_valid,
  output logic                    o_done,
  output logic [TOTAL_BITS-1:0]   o_remainder,
  output logic [3*STOCK_BITS-1:0] o_stock
);

  localparam logic [TOTAL_BITS-1:0] C0 = TOTAL_BITS'(COIN0_VAL);
  localparam logic [TOTAL_BITS-1:0] C1 = TOTAL_BITS'(COIN1_VAL);
  localparam logic [TOTAL_BITS-1:0] C2 = TOTAL_BITS'(COIN2_VAL);
  localparam logic [STOCK_BITS-1:0] STOCK_MAX  = {STOCK_BITS{1'b1}};
  localparam logic [STOCK_BITS-1:0] STOCK_INIT = STOCK_BITS'(INIT_STOCK);

  typedef enum logic [1:0] {IDLE, SELECT, OFFER, DONE} state_t;

  state_t                          state, state_nxt;
  logic [TOTAL_BITS-1:0]           remaining, remaining_nxt;
  logic [TOTAL_BITS-1:0]           remainder, remainder_nxt;
  logic [2:0]                      coin_sel, coin_sel_nxt;
  logic [2:0]                      pick;
  logic [2:0][STOCK_BITS-1:0]      stock;
  logic                            ack_fire;

  // Greedy choice: largest denomination that fits and is in stock.
  function automatic logic [2:0] pick_coin(
    input logic [TOTAL_BITS-1:0]      amt,
    input logic [2:0][STOCK_BITS-1:0] stk
  );
    if (C2 <= amt && stk[2] != '0) return 3'b100;
    if (C1 <= amt && stk[1] != '0) return 3'b010;
    if (C0 <= amt && stk[0] != '0) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [TOTAL_BITS-1:0] coin_value(input logic [2:0] sel);
    case (sel)
      3'b100:  return C2;
      3'b010:  return C1;
      3'b001:  return C0;
      default: return '0;
    endcase
  endfunction

  // Saturating refill; a refill and a dispense in the same cycle cancel.
  function automatic logic [STOCK_BITS-1:0] stock_next(
    input logic [STOCK_BITS-1:0] cur,
    input logic                  inc,
    input logic                  dec
  );
    if (inc && !dec) return (cur == STOCK_MAX) ? cur : cur + 1'b1;
    if (dec && !inc) return cur - 1'b1;
    return cur;
  endfunction

  assign pick     = pick_coin(remaining, stock);
  assign ack_fire = (state == OFFER) && i_coin_ack;

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    remainder_nxt = remainder;
    coin_sel_nxt  = coin_sel;
    case (state)
      IDLE: begin
        if (i_start) begin
          remainder_nxt = '0;
          if (i_amount != '0) begin
            remaining_nxt = i_amount;
            state_nxt     = SELECT;
          end else begin
            state_nxt     = DONE;
          end
        end
      end
      SELECT: begin
        if (pick != 3'b000) begin
          coin_sel_nxt = pick;
          state_nxt    = OFFER;
        end else begin
          remainder_nxt = remaining;
          state_nxt     = DONE;
        end
      end
      OFFER: begin
        // SELECT only offers coins that fit, so this cannot underflow.
        if (i_coin_ack) begin
          remaining_nxt = remaining - coin_value(coin_sel);
          state_nxt     = SELECT;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      remainder <= '0;
      coin_sel  <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      remainder <= remainder_nxt;
      coin_sel  <= coin_sel_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) stock[k] <= STOCK_INIT;
    end else begin
      for (int k = 0; k < 3; k++)
        stock[k] <= stock_next(stock[k], i_refill[k], ack_fire && coin_sel[k]);
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_coin_valid = (state == OFFER);
  assign o_coin       = (state == OFFER) ? coin_sel : 3'b000;
  assign o_done       = (state == DONE);
  assign o_remainder  = remainder;
  assign o_stock      = stock;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy selection, remainder, stock
// exhaustion, held offers, asynchronous abort, and refill saturation.
module tb_change_dispenser;
  localparam int TB = 31;
  localparam int SB = 8;

  logic            clk;
  logic            reset;
  logic            i_start;
  logic [TB-1:0]   i_amount;
  logic            i_coin_ack;
  logic [2:0]      i_refill;
  logic            o_busy;
  logic [2:0]      o_coin;
  logic            o_coin_valid;
  logic            o_done;
  logic [TB-1:0]   o_remainder;
  logic [3*SB-1:0] o_stock;

  int errors = 0;
  int checks = 0;

  change_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_amount     (i_amount),
    .i_coin_ack   (i_coin_ack),
    .i_refill     (i_refill),
    .o_busy       (o_busy),
    .o_coin       (o_coin),
    .o_coin_valid (o_coin_valid),
    .o_done       (o_done),
    .o_remainder  (o_remainder),
    .o_stock      (o_stock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] stk(input int s2, input int s1, input int s0);
    logic [23:0] v;
    v = {8'(s2), 8'(s1), 8'(s0)};
    return 64'(v);
  endfunction

  task automatic start(input int amount);
    i_start  = 1'b1;
    i_amount = TB'(amount);
    tick();
    i_start  = 1'b0;
    i_amount = '0;
  endtask

  // Called in the cycle after a start/ack edge (state SELECT).
  task automatic offer_ack(input string tag, input logic [2:0] coin);
    tick();
    chk({tag, "_valid"}, 64'(o_coin_valid), 64'd1);
    chk({tag, "_coin"},  64'(o_coin),       64'(coin));
    i_coin_ack = 1'b1;
    tick();
    i_coin_ack = 1'b0;
    chk({tag, "_drop"},  64'(o_coin_valid), 64'd0);
  endtask

  task automatic expect_done(input string tag, input int rem);
    tick();
    chk({tag, "_done"}, 64'(o_done),      64'd1);
    chk({tag, "_rem"},  64'(o_remainder), 64'(rem));
    tick();
    chk({tag, "_done_w"}, 64'(o_done), 64'd0);
    chk({tag, "_idle"},   64'(o_busy), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    i_start    = 1'b0;
    i_amount   = '0;
    i_coin_ack = 1'b0;
    i_refill   = 3'b000;
    #3;
    chk("rst_busy",  64'(o_busy),       64'd0);
    chk("rst_valid", 64'(o_coin_valid), 64'd0);
    chk("rst_coin",  64'(o_coin),       64'd0);
    chk("rst_done",  64'(o_done),       64'd0);
    chk("rst_rem",   64'(o_remainder),  64'd0);
    chk("rst_stock", 64'(o_stock),      stk(10, 10, 10));
    tick();
    reset = 1'b0;
    tick();

    // 1600 = 1000 + 500 + 100
    start(1600);
    chk("t1_busy", 64'(o_busy), 64'd1);
    offer_ack("t1_c2", 3'b100);
    offer_ack("t1_c1", 3'b010);
    offer_ack("t1_c0", 3'b001);
    expect_done("t1", 0);
    chk("t1_stock", 64'(o_stock), stk(9, 9, 9));

    // 1650 leaves 50 undispensable
    start(1650);
    offer_ack("t2_c2", 3'b100);
    offer_ack("t2_c1", 3'b010);
    offer_ack("t2_c0", 3'b001);
    expect_done("t2", 50);
    chk("t2_stock", 64'(o_stock), stk(8, 8, 8));

    // Fresh reset, refill check, then drain denomination 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_refill = 3'b100;
    tick();
    i_refill = 3'b000;
    chk("t3_refill", 64'(o_stock), stk(11, 10, 10));
    for (int n = 0; n < 10; n++) begin
      start(500);
      offer_ack("t3_drain", 3'b010);
      expect_done("t3_drain", 0);
    end
    chk("t3_empty1", 64'(o_stock), stk(11, 0, 10));
    start(600);
    for (int n = 0; n < 6; n++) offer_ack("t3_c0", 3'b001);
    expect_done("t3", 0);
    chk("t3_stock", 64'(o_stock), stk(11, 0, 4));

    // Held offer: 5 cycles without ack; a stray i_start is ignored
    start(1000);
    tick();
    for (int n = 0; n < 5; n++) begin
      chk("t4_hold_valid", 64'(o_coin_valid), 64'd1);
      chk("t4_hold_coin",  64'(o_coin),       64'd4);
      chk("t4_hold_stock", 64'(o_stock),      stk(11, 0, 4));
      if (n == 2) begin
        i_start  = 1'b1;
        i_amount = TB'(100);
      end
      if (n < 4) tick();
      i_start  = 1'b0;
      i_amount = '0;
    end
    i_coin_ack = 1'b1;
    tick();
    i_coin_ack = 1'b0;
    chk("t4_dec", 64'(o_stock), stk(10, 0, 4));
    expect_done("t4", 0);
    chk("t4_stock", 64'(o_stock), stk(10, 0, 4));

    // Asynchronous reset during an offer aborts the request
    start(1600);
    tick();
    chk("t5_offer", 64'(o_coin_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_valid", 64'(o_coin_valid), 64'd0);
    chk("t5_coin",  64'(o_coin),       64'd0);
    chk("t5_busy",  64'(o_busy),       64'd0);
    chk("t5_stock", 64'(o_stock),      stk(10, 10, 10));
    tick();
    reset = 1'b0;
    tick();
    chk("t5_nodone", 64'(o_done), 64'd0);
    start(0);
    chk("t5_zero_done", 64'(o_done),      64'd1);
    chk("t5_zero_rem",  64'(o_remainder), 64'd0);
    tick();
    chk("t5_zero_w", 64'(o_done), 64'd0);

    // Refill saturation, then refill coinciding with a dispense
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_refill = 3'b001;
    for (int n = 0; n < 250; n++) tick();
    i_refill = 3'b000;
    chk("t6_sat", 64'(o_stock), stk(10, 10, 255));
    start(1000);
    tick();
    chk("t6_coin", 64'(o_coin), 64'd4);
    i_coin_ack = 1'b1;
    i_refill   = 3'b100;
    tick();
    i_coin_ack = 1'b0;
    i_refill   = 3'b000;
    chk("t6_cancel", 64'(o_stock), stk(10, 10, 255));
    expect_done("t6", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
